// File: rtl/exec_seq.sv
// Fetch/execute/writeback sequencer for the 16-bit calculator core.
// Conditional branches (Bcc) are decoded only when EXEC_SEQ_BCC_EN is defined.
//
// state | meaning
// IF    | wait for imem_ready, latch instruction into ir
// EX    | calculator settles on ir; writeback strobes are set up
// WB    | strobes high, flags/pc updated
// HALT  | absorbing stop, pc/ir/flags frozen until rst_n
module exec_seq (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] alu_instr,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_code,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [3:0]  flags,
  output logic        out_valid,
  output logic        halted
);

  typedef enum logic [1:0] {S_IF, S_EX, S_WB, S_HALT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;

  logic [3:0]  op3;
  logic        is_calc, alu_wr, is_cmp, is_out, is_hlt, is_li, is_b, taken;
  logic [15:0] pc_inc, br_target, next_pc;
  logic        unused_ok;

  assign imem_addr = pc;
  assign alu_instr = ir;
  assign rf_waddr  = ir[10:8];
  assign unused_ok = ^alu_result;

  assign op3       = ir[7:4];
  assign is_calc   = (ir[15:14] == 2'b11);
  assign alu_wr    = is_calc && ((op3 <= 4'd4) || ((op3 >= 4'd8) && (op3 <= 4'd11)));
  assign is_cmp    = is_calc && (op3 == 4'd5);
  assign is_out    = is_calc && (op3 == 4'd13);
  assign is_hlt    = is_calc && (op3 == 4'd15);
  assign is_li     = (ir[15:11] == 5'b10000);
  assign is_b      = (ir[15:11] == 5'b10100);
  assign pc_inc    = pc + 16'd1;
  assign br_target = pc_inc + {{8{ir[7]}}, ir[7:0]};

`ifdef EXEC_SEQ_BCC_EN
  logic is_bcc, cond_hit;
  assign is_bcc = (ir[15:11] == 5'b10111);

  // flags[3:0] = {S,Z,C,V}; flags here are the value from before this WB
  always_comb begin
    cond_hit = 1'b0;
    case (ir[10:8])
      3'b000:  cond_hit = flags[2];
      3'b001:  cond_hit = flags[3] ^ flags[0];
      3'b010:  cond_hit = flags[2] | (flags[3] ^ flags[0]);
      3'b011:  cond_hit = ~flags[2];
      default: cond_hit = 1'b0;
    endcase
  end

  assign taken = is_b || (is_bcc && cond_hit);
`else
  assign taken = is_b;
`endif

  assign next_pc = is_hlt ? pc : (taken ? br_target : pc_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IF;
      pc        <= 16'h0000;
      ir        <= 16'h0000;
      flags     <= 4'h0;
      rf_we     <= 1'b0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        S_IF: begin
          if (imem_ready) begin
            ir    <= imem_rdata;
            state <= S_EX;
          end
        end
        S_EX: begin
          rf_we     <= alu_wr || is_li;
          out_valid <= is_out;
          state     <= S_WB;
        end
        S_WB: begin
          rf_we     <= 1'b0;
          out_valid <= 1'b0;
          if (alu_wr || is_cmp)
            flags <= alu_code;
          pc <= next_pc;
          if (is_hlt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_IF;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: state <= S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_seq.sv
// Directed bench for exec_seq: vector table for the main program plus
// hand-written reset, stall, halt and wrap-around sequences.
module tb_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_ready = 1'b0;
  logic [15:0] alu_instr;
  logic [15:0] alu_result = 16'h0000;
  logic [3:0]  alu_code = 4'h0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [3:0]  flags;
  logic        out_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

`ifdef EXEC_SEQ_BCC_EN
  localparam bit BCC = 1'b1;
`else
  localparam bit BCC = 1'b0;
`endif

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  code;
    logic        we;
    logic [2:0]  wa;
    logic        outv;
    logic [3:0]  fl;
    logic [15:0] pc;
    logic        halt;
  } vec_t;

  vec_t tbl[15];

  exec_seq dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .alu_instr(alu_instr), .alu_result(alu_result),
    .alu_code(alu_code), .rf_we(rf_we), .rf_waddr(rf_waddr), .flags(flags),
    .out_valid(out_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enter at a negedge in IF; leave at the negedge after WB (back in IF or HALT).
  task automatic run_vec(input vec_t v, input string tag);
    imem_rdata = v.instr;
    imem_ready = 1'b1;
    alu_code   = v.code;
    alu_result = 16'h1234;
    @(posedge clk); @(negedge clk);
    chk({tag, " ex.instr"}, alu_instr, v.instr);
    chk({tag, " ex.we"}, {15'd0, rf_we}, 16'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, " wb.we"}, {15'd0, rf_we}, {15'd0, v.we});
    chk({tag, " wb.out"}, {15'd0, out_valid}, {15'd0, v.outv});
    chk({tag, " wb.waddr"}, {13'd0, rf_waddr}, {13'd0, v.wa});
    @(posedge clk); @(negedge clk);
    chk({tag, " pc"}, imem_addr, v.pc);
    chk({tag, " flags"}, {12'd0, flags}, {12'd0, v.fl});
    chk({tag, " halted"}, {15'd0, halted}, {15'd0, v.halt});
    chk({tag, " post.we"}, {14'd0, rf_we, out_valid}, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst.pc", imem_addr, 16'h0000);
    chk("rst.ir", alu_instr, 16'h0000);
    chk("rst.outs", {11'd0, flags, rf_we, out_valid}, 16'd0);
    chk("rst.halted", {15'd0, halted}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t li;
    logic [15:0] pc_hold;
    logic [3:0]  fl_hold;

    // instr,   code,  we, wa, out, flags,  pc(after WB),             halt
    tbl[0]  = '{16'hC200, 4'h4, 1, 3'd2, 0, 4'h4, 16'd1,                  0}; // ADD r2, Z
    tbl[1]  = '{16'hB804, 4'hF, 0, 3'd0, 0, 4'h4, BCC ? 16'd6  : 16'd2,   0}; // BE +4
    tbl[2]  = '{16'hA0FD, 4'hF, 0, 3'd0, 0, 4'h4, BCC ? 16'd4  : 16'd0,   0}; // B -3
    tbl[3]  = '{16'hC350, 4'h8, 0, 3'd3, 0, 4'h8, BCC ? 16'd5  : 16'd1,   0}; // CMP, S
    tbl[4]  = '{16'hB9FE, 4'hF, 0, 3'd1, 0, 4'h8, BCC ? 16'd4  : 16'd2,   0}; // BLT -2
    tbl[5]  = '{16'hBA02, 4'hF, 0, 3'd2, 0, 4'h8, BCC ? 16'd7  : 16'd3,   0}; // BLE +2
    tbl[6]  = '{16'hBB01, 4'hF, 0, 3'd3, 0, 4'h8, BCC ? 16'd9  : 16'd4,   0}; // BNE +1
    tbl[7]  = '{16'hBC05, 4'hF, 0, 3'd4, 0, 4'h8, BCC ? 16'd10 : 16'd5,   0}; // cond 100
    tbl[8]  = '{16'hB810, 4'hF, 0, 3'd0, 0, 4'h8, BCC ? 16'd11 : 16'd6,   0}; // BE, Z=0
    tbl[9]  = '{16'hC580, 4'h3, 1, 3'd5, 0, 4'h3, BCC ? 16'd12 : 16'd7,   0}; // op 1000
    tbl[10] = '{16'hC060, 4'hF, 0, 3'd0, 0, 4'h3, BCC ? 16'd13 : 16'd8,   0}; // op 0110 NOP
    tbl[11] = '{16'h0123, 4'hF, 0, 3'd1, 0, 4'h3, BCC ? 16'd14 : 16'd9,   0}; // class 00 NOP
    tbl[12] = '{16'h87FF, 4'hF, 1, 3'd7, 0, 4'h3, BCC ? 16'd15 : 16'd10,  0}; // LI r7
    tbl[13] = '{16'hC0D0, 4'hF, 0, 3'd0, 1, 4'h3, BCC ? 16'd16 : 16'd11,  0}; // OUT
    tbl[14] = '{16'hC0F0, 4'hF, 0, 3'd0, 0, 4'h3, BCC ? 16'd16 : 16'd11,  1}; // HLT

    do_reset();
    li = '{16'h815A, 4'hF, 1, 3'd1, 0, 4'h0, 16'd1, 0};
    run_vec(li, "li");

    // fetch stalled for four cycles, instruction completes in cycle 7
    do_reset();
    imem_rdata = 16'h815A;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      chk("stall.pc", imem_addr, 16'h0000);
      chk("stall.ir", alu_instr, 16'h0000);
    end
    imem_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("stall.c6.we", {15'd0, rf_we}, 16'd0);
    @(posedge clk); @(negedge clk);
    chk("stall.c7.we", {15'd0, rf_we}, 16'd1);
    @(posedge clk); @(negedge clk);
    chk("stall.pc.end", imem_addr, 16'h0001);

    do_reset();
    for (int i = 0; i < 15; i++)
      run_vec(tbl[i], $sformatf("vec%0d", i));

    // HALT absorbs everything
    pc_hold = BCC ? 16'd16 : 16'd11;
    fl_hold = 4'h3;
    imem_rdata = 16'hC200;
    imem_ready = 1'b1;
    alu_code   = 4'hC;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      chk("halt.pc", imem_addr, pc_hold);
      chk("halt.ir", alu_instr, 16'hC0F0);
      chk("halt.flags", {12'd0, flags}, {12'd0, fl_hold});
      chk("halt.strobes", {13'd0, halted, rf_we, out_valid}, 16'b100);
    end

    // reset abandons an ALU write caught in EX
    do_reset();
    imem_rdata = 16'hC200;
    imem_ready = 1'b1;
    alu_code   = 4'h4;
    @(posedge clk); @(negedge clk);
    chk("mid.ex.instr", alu_instr, 16'hC200);
    rst_n = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("mid.rst.ir", alu_instr, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("mid.we", {14'd0, rf_we, out_valid}, 16'd0);
      chk("mid.pc", imem_addr, 16'h0000);
      chk("mid.flags", {12'd0, flags}, 16'd0);
    end

    // branch backwards from 0 wraps to FFFF, then pc+1 wraps to 0
    run_vec('{16'hA0FE, 4'hF, 0, 3'd0, 0, 4'h0, 16'hFFFF, 0}, "wrap.b");
    run_vec('{16'h0000, 4'hF, 0, 3'd0, 0, 4'h0, 16'h0000, 0}, "wrap.nop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_seq.md
EXEC_SEQ -- requirements
Module: exec_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port imem_addr, output, 16 bits: instruction fetch address, always equal to the PC register.
REQ-004 SHALL have port imem_rdata, input, 16 bits: fetched instruction word.
REQ-005 SHALL have port imem_ready, input, 1 bit: imem_rdata is valid this cycle.
REQ-006 SHALL have port alu_instr, output, 16 bits: latched IR driven to the calculator instr input.
REQ-007 SHALL have port alu_result, input, 16 bits: calculator result.
REQ-008 SHALL have port alu_code, input, 4 bits: calculator flags {s,z,c,v}.
REQ-009 SHALL have port rf_we, output, 1 bit: register-file write strobe, one cycle wide.
REQ-010 SHALL have port rf_waddr, output, 3 bits: destination register, equal to ir[10:8].
REQ-011 SHALL have port flags, output, 4 bits: registered condition code {S,Z,C,V}.
REQ-012 SHALL have port out_valid, output, 1 bit: one-cycle strobe indicating alu_result is OUT data.
REQ-013 SHALL have port halted, output, 1 bit: high while in the HALT state.

Function
REQ-014 SHALL implement states IF, EX, WB and HALT.
REQ-015 IF: SHALL hold the state while imem_ready=0; when imem_ready=1, SHALL latch ir<=imem_rdata and go to EX.
REQ-016 EX: SHALL take one cycle for the calculator result to settle and SHALL go to WB unconditionally.
REQ-017 WB: SHALL perform the writeback/PC action of the decoded class (REQ-018..REQ-022), SHALL set pc<=next PC and go to IF, except HLT which goes to HALT.
REQ-018 ALU class (ir[15:14]=11, op3=ir[7:4] in {0000-0100, 1000-1011}): SHALL pulse rf_we=1, SHALL load flags<=alu_code, and SHALL set pc<=pc+1.
REQ-019 CMP (op3=0101): SHALL load flags only, with rf_we=0. OUT (op3=1101): SHALL pulse out_valid with flags unchanged. HLT (op3=1111): SHALL hold pc and go to HALT. Any other op3: NOP, pc+1.
REQ-020 LI (ir[15:11]=10000): SHALL pulse rf_we with flags unchanged and pc+1.
REQ-021 B (ir[15:11]=10100): SHALL set pc<=pc+1+sext(ir[7:0]) using 16-bit wrap-around arithmetic.
REQ-022 Bcc (ir[15:11]=10111, cond=ir[10:8]): BE=000 taken on Z; BLT=001 on S^V; BLE=010 on Z|(S^V); BNE=011 on !Z. Cond 100-111 SHALL be not taken. Taken uses the REQ-021 target; not taken uses pc+1. The condition SHALL use the flags value registered before this WB.
REQ-023 Any other ir[15:14] encoding: SHALL be a NOP with pc+1.
REQ-024 PC at 16'hFFFF SHALL wrap to 16'h0000.
REQ-025 rf_we and out_valid SHALL be asserted only in WB, and never both in the same cycle.
REQ-026 HALT: SHALL be absorbing; pc, ir and flags SHALL be frozen; only rst_n exits HALT.
REQ-027 Minimum instruction latency SHALL be 3 cycles; each cycle imem_ready stays low SHALL add 1 cycle.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IF, pc=0, ir=0, flags=0, rf_we=0, out_valid=0 and halted=0.
REQ-029 A reset asserted in any state SHALL abandon the in-flight instruction, with no write or strobe emitted.
REQ-030 After rst_n deasserts, the first fetch SHALL be at address 0 on the next clk edge.

Configuration
REQ-031 With macro EXEC_SEQ_BCC_EN defined, Bcc SHALL behave per REQ-022.
REQ-032 With EXEC_SEQ_BCC_EN undefined, Bcc encodings SHALL be NOPs (pc+1) and no condition logic SHALL be present.

Verification
REQ-033 Reset, then imem_ready=1 and LI r1,0x5A -> rf_we pulses in cycle 3 with rf_waddr=1, pc=1, flags=0000.
REQ-034 ADD giving alu_result=0 and alu_code=0100 -> rf_we=1, flags=0100; a following BE with offset +4 at pc=1 -> pc=6.
REQ-035 CMP with alu_code=1000, then BLT offset 8'hFE at pc=5 -> rf_we stays 0 and pc becomes 4; with EXEC_SEQ_BCC_EN undefined -> pc=6.
REQ-036 imem_ready held low for 4 cycles -> state stays IF and pc is stable; the instruction completes in 7 cycles.
REQ-037 OUT, then HLT -> out_valid pulses once, halted=1, pc frozen; rst_n pulse mid-EX -> no rf_we, pc=0.
